// File: rtl/wb_arbiter_if.sv
// Bus bundle between the WB stage, the multi-cycle unit, the ID stage and the
// write-back arbiter that owns the register file write port.
interface wb_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        mc_valid;
    logic [4:0]  mc_waddr;
    logic [31:0] mc_wdata;
    logic        mc_ready;
    logic        iss_valid;
    logic [4:0]  iss_waddr;
    logic        re1;
    logic        re2;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        id_we;
    logic [4:0]  id_waddr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        stall;
    logic        pipe_hold;

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  mc_valid, mc_waddr, mc_wdata,
        output mc_ready,
        input  iss_valid, iss_waddr,
        input  re1, re2, raddr1, raddr2, id_we, id_waddr,
        output we, waddr, wdata, stall, pipe_hold
    );

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        output mc_valid, mc_waddr, mc_wdata,
        input  mc_ready,
        output iss_valid, iss_waddr,
        output re1, re2, raddr1, raddr2, id_we, id_waddr,
        input  we, waddr, wdata, stall, pipe_hold
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: pipeline writes win the register file port, multi-cycle
// results wait in a 2-entry FIFO with an age-based anti-starvation hold and a busy scoreboard.
module wb_arbiter (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    logic [4:0]  fifo_addr_r [2];
    logic [31:0] fifo_data_r [2];
    logic        rd_ptr_r;
    logic [1:0]  count_r;
    logic [1:0]  age_r;
    logic        pipe_hold_r;
    logic [31:0] busy_r;

    logic        head_valid_s;
    logic [4:0]  head_addr_s;
    logic [31:0] head_data_s;
    logic        sel_head_s;
    logic        sel_pipe_s;
    logic        push_s;
    logic        pop_s;
    logic        wr_ptr_s;
    logic        head_write_s;
    logic        mc_ready_s;
    logic        we_s;
    logic [4:0]  waddr_s;
    logic [31:0] wdata_s;
    logic        stall_s;
    logic [31:0] release_mask_s;
    logic [31:0] busy_eff_s;
    logic [31:0] busy_nxt_s;
    logic [1:0]  age_nxt_s;
    logic        hold_nxt_s;

    function automatic logic [31:0] dec32(input logic [4:0] a);
        dec32 = 32'd1 << a;
    endfunction

    // Port selection, FIFO handshake and register file write data.
    always_comb begin
        head_valid_s = (count_r != 2'd0);
        head_addr_s  = fifo_addr_r[rd_ptr_r];
        head_data_s  = fifo_data_r[rd_ptr_r];
        sel_head_s   = head_valid_s & (pipe_hold_r | ~bus.pipe_we);
        sel_pipe_s   = ~sel_head_s & bus.pipe_we;
        pop_s        = sel_head_s;
        mc_ready_s   = (count_r < 2'd2) & ~rst;
        push_s       = bus.mc_valid & mc_ready_s;
        wr_ptr_s     = rd_ptr_r ^ count_r[0];
        head_write_s = sel_head_s & (head_addr_s != 5'd0);
        we_s         = 1'b0;
        waddr_s      = 5'd0;
        wdata_s      = 32'd0;
        if (~rst & head_write_s) begin
            we_s    = 1'b1;
            waddr_s = head_addr_s;
            wdata_s = head_data_s;
        end else if (~rst & sel_pipe_s & (bus.pipe_waddr != 5'd0)) begin
            we_s    = 1'b1;
            waddr_s = bus.pipe_waddr;
            wdata_s = bus.pipe_wdata;
        end else begin
            we_s    = 1'b0;
        end
    end

    // Scoreboard, stall generation and head age tracking.
    always_comb begin
        release_mask_s = head_write_s ? dec32(head_addr_s) : 32'd0;
        busy_eff_s     = busy_r & ~release_mask_s;
        stall_s        = ~rst & ((bus.re1 & busy_eff_s[bus.raddr1]) |
                                 (bus.re2 & busy_eff_s[bus.raddr2]) |
                                 (bus.id_we & busy_eff_s[bus.id_waddr]) |
                                 pipe_hold_r);
        busy_nxt_s     = busy_r & ~release_mask_s;
        if (bus.iss_valid & (bus.iss_waddr != 5'd0)) begin
            busy_nxt_s = busy_nxt_s | dec32(bus.iss_waddr);
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0]  = 1'b0;
        if (~head_valid_s | pop_s) begin
            age_nxt_s = 2'd0;
        end else if (age_r == 2'd3) begin
            age_nxt_s = 2'd3;
        end else begin
            age_nxt_s = age_r + 2'd1;
        end
        // Hold is raised on the edge where the head completes its third blocked cycle.
        hold_nxt_s = head_valid_s & ~pop_s & (age_nxt_s == 2'd3);
    end

    // State registers; queued results are discarded by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_addr_r[0] <= 5'd0;
            fifo_addr_r[1] <= 5'd0;
            fifo_data_r[0] <= 32'd0;
            fifo_data_r[1] <= 32'd0;
            rd_ptr_r       <= 1'b0;
            count_r        <= 2'd0;
            age_r          <= 2'd0;
            pipe_hold_r    <= 1'b0;
            busy_r         <= 32'd0;
        end else begin
            if (push_s) begin
                fifo_addr_r[wr_ptr_s] <= bus.mc_waddr;
                fifo_data_r[wr_ptr_s] <= bus.mc_wdata;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r     <= count_r + {1'b0, push_s} - {1'b0, pop_s};
            age_r       <= age_nxt_s;
            pipe_hold_r <= hold_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign bus.mc_ready  = mc_ready_s;
    assign bus.we        = we_s;
    assign bus.waddr     = waddr_s;
    assign bus.wdata     = wdata_s;
    assign bus.stall     = stall_s;
    assign bus.pipe_hold = pipe_hold_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus a randomized run against a
// queue-based reference model of the port, FIFO, scoreboard and hold rules.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;

    wb_arbiter_if bus();
    wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic idle();
        bus.pipe_we = 1'b0; bus.pipe_waddr = 5'd0; bus.pipe_wdata = 32'd0;
        bus.mc_valid = 1'b0; bus.mc_waddr = 5'd0; bus.mc_wdata = 32'd0;
        bus.iss_valid = 1'b0; bus.iss_waddr = 5'd0;
        bus.re1 = 1'b0; bus.re2 = 1'b0; bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
        bus.id_we = 1'b0; bus.id_waddr = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd5; bus.pipe_wdata = 32'hDEAD_BEEF;
        bus.re1 = 1'b1; bus.raddr1 = 5'd5;
        sample();
        checks++;
        if ({bus.we, bus.waddr, bus.wdata, bus.mc_ready, bus.stall, bus.pipe_hold} !== 41'd0)
            $display("FAIL reset_outputs: we=%0b waddr=%0d wdata=%h mc_ready=%0b stall=%0b hold=%0b, want all 0",
                     bus.we, bus.waddr, bus.wdata, bus.mc_ready, bus.stall, bus.pipe_hold);
        else passes++;
        step();
        rst = 1'b0;
        idle();
        sample();
        checks++;
        if (bus.mc_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b want 1", bus.mc_ready);
        else passes++;
        step();
    endtask

    task automatic test_pipe_only();
        idle();
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd5; bus.pipe_wdata = 32'h1234_5678;
        sample();
        checks++;
        if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd5, 32'h1234_5678})
            $display("FAIL pipe_only: got we=%0b waddr=%0d wdata=%h want 1/5/12345678", bus.we, bus.waddr, bus.wdata);
        else passes++;
        step();
    endtask

    task automatic test_r0();
        idle();
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd0; bus.pipe_wdata = 32'hFFFF_FFFF;
        sample();
        checks++;
        if ({bus.we, bus.waddr, bus.wdata} !== 38'd0)
            $display("FAIL r0_pipe: got we=%0b waddr=%0d wdata=%h want 0/0/0", bus.we, bus.waddr, bus.wdata);
        else passes++;
        step();
        idle();
        bus.mc_valid = 1'b1; bus.mc_waddr = 5'd0; bus.mc_wdata = 32'hCAFE_0000;
        step();
        idle();
        bus.re1 = 1'b1; bus.raddr1 = 5'd0;
        sample();
        checks++;
        if ({bus.we, bus.waddr, bus.wdata, bus.stall} !== 39'd0)
            $display("FAIL r0_head: got we=%0b waddr=%0d wdata=%h stall=%0b want 0/0/0/0",
                     bus.we, bus.waddr, bus.wdata, bus.stall);
        else passes++;
        step();
        idle();
        bus.mc_valid = 1'b1; bus.mc_waddr = 5'd2; bus.mc_wdata = 32'h2;
        step();
        idle();
        step();
        idle();
        sample();
        checks++;
        if (bus.we !== 1'b0 || bus.mc_ready !== 1'b1)
            $display("FAIL r0_popped: got we=%0b mc_ready=%0b want 0/1", bus.we, bus.mc_ready);
        else passes++;
        step();
    endtask

    task automatic test_scoreboard();
        idle();
        bus.iss_valid = 1'b1; bus.iss_waddr = 5'd7;
        sample();
        checks++;
        if (bus.stall !== 1'b0) $display("FAIL sb_issue_stall: got %0b want 0", bus.stall);
        else passes++;
        step();
        idle();
        bus.re1 = 1'b1; bus.raddr1 = 5'd7;
        sample();
        checks++;
        if (bus.stall !== 1'b1) $display("FAIL sb_re1_stall: got %0b want 1", bus.stall);
        else passes++;
        step();
        idle();
        bus.re2 = 1'b1; bus.raddr2 = 5'd7;
        bus.mc_valid = 1'b1; bus.mc_waddr = 5'd7; bus.mc_wdata = 32'h0000_0777;
        sample();
        checks++;
        if (bus.stall !== 1'b1) $display("FAIL sb_re2_stall: got %0b want 1", bus.stall);
        else passes++;
        step();
        idle();
        bus.re1 = 1'b1; bus.raddr1 = 5'd7;
        sample();
        checks++;
        if ({bus.stall, bus.we, bus.waddr, bus.wdata} !== {1'b0, 1'b1, 5'd7, 32'h0000_0777})
            $display("FAIL sb_release: got stall=%0b we=%0b waddr=%0d wdata=%h want 0/1/7/00000777",
                     bus.stall, bus.we, bus.waddr, bus.wdata);
        else passes++;
        step();
        idle();
        bus.id_we = 1'b1; bus.id_waddr = 5'd7;
        sample();
        checks++;
        if (bus.stall !== 1'b0 || bus.we !== 1'b0)
            $display("FAIL sb_cleared: got stall=%0b we=%0b want 0/0", bus.stall, bus.we);
        else passes++;
        step();
    endtask

    task automatic test_starvation();
        for (int c = 0; c < 6; c++) begin
            idle();
            bus.pipe_we = (c != 4); bus.pipe_waddr = 5'(c + 1); bus.pipe_wdata = 32'(c + 100);
            if (c == 0) begin
                bus.mc_valid = 1'b1; bus.mc_waddr = 5'd9; bus.mc_wdata = 32'hA5A5_A5A5;
            end
            sample();
            checks++;
            if (c == 4) begin
                if ({bus.pipe_hold, bus.stall, bus.we, bus.waddr, bus.wdata} !== {1'b1, 1'b1, 1'b1, 5'd9, 32'hA5A5_A5A5})
                    $display("FAIL starve_hold: got hold=%0b stall=%0b we=%0b waddr=%0d wdata=%h want 1/1/1/9/a5a5a5a5",
                             bus.pipe_hold, bus.stall, bus.we, bus.waddr, bus.wdata);
                else passes++;
            end else begin
                if ({bus.pipe_hold, bus.we, bus.waddr, bus.wdata} !== {1'b0, 1'b1, 5'(c + 1), 32'(c + 100)})
                    $display("FAIL starve_cycle%0d: got hold=%0b we=%0b waddr=%0d wdata=%0d want 0/1/%0d/%0d",
                             c, bus.pipe_hold, bus.we, bus.waddr, bus.wdata, c + 1, c + 100);
                else passes++;
            end
            step();
        end
    endtask

    task automatic test_full_fifo();
        logic [4:0]  exp_a [2];
        logic [31:0] exp_d [2];
        exp_a[0] = 5'd10; exp_a[1] = 5'd11;
        exp_d[0] = 32'h10; exp_d[1] = 32'h11;
        for (int c = 0; c < 3; c++) begin
            idle();
            bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd1; bus.pipe_wdata = 32'd1;
            bus.mc_valid = 1'b1; bus.mc_waddr = 5'(10 + c); bus.mc_wdata = 32'(16 + c);
            sample();
            checks++;
            if (bus.mc_ready !== (c < 2))
                $display("FAIL full_ready%0d: got %0b want %0b", c, bus.mc_ready, (c < 2));
            else passes++;
            step();
        end
        for (int c = 0; c < 3; c++) begin
            idle();
            sample();
            checks++;
            if (c < 2) begin
                if ({bus.we, bus.waddr, bus.wdata, bus.mc_ready} !== {1'b1, exp_a[c], exp_d[c], (c == 1)})
                    $display("FAIL full_order%0d: got we=%0b waddr=%0d wdata=%h ready=%0b want 1/%0d/%h/%0b",
                             c, bus.we, bus.waddr, bus.wdata, bus.mc_ready, exp_a[c], exp_d[c], (c == 1));
                else passes++;
            end else begin
                if (bus.we !== 1'b0) $display("FAIL full_no_pushthrough: got we=%0b want 0", bus.we);
                else passes++;
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        idle();
        bus.iss_valid = 1'b1; bus.iss_waddr = 5'd3;
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd1;
        bus.mc_valid = 1'b1; bus.mc_waddr = 5'd3; bus.mc_wdata = 32'h33;
        step();
        idle();
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd1;
        bus.mc_valid = 1'b1; bus.mc_waddr = 5'd4; bus.mc_wdata = 32'h44;
        step();
        idle();
        bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd1; bus.pipe_wdata = 32'd1;
        bus.re1 = 1'b1; bus.raddr1 = 5'd3;
        sample();
        checks++;
        if (bus.stall !== 1'b1 || bus.mc_ready !== 1'b0)
            $display("FAIL rstmid_before: got stall=%0b ready=%0b want 1/0", bus.stall, bus.mc_ready);
        else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.we, bus.waddr, bus.wdata, bus.mc_ready, bus.stall, bus.pipe_hold} !== 41'd0)
            $display("FAIL rstmid_outputs: got we=%0b waddr=%0d wdata=%h ready=%0b stall=%0b hold=%0b want all 0",
                     bus.we, bus.waddr, bus.wdata, bus.mc_ready, bus.stall, bus.pipe_hold);
        else passes++;
        step();
        rst = 1'b0;
        idle();
        bus.re1 = 1'b1; bus.raddr1 = 5'd3;
        sample();
        checks++;
        if ({bus.mc_ready, bus.stall, bus.we} !== 3'b100)
            $display("FAIL rstmid_after: got ready=%0b stall=%0b we=%0b want 1/0/0", bus.mc_ready, bus.stall, bus.we);
        else passes++;
        step();
        idle();
    endtask

    task automatic test_random();
        logic [4:0]  mq_a [$];
        logic [31:0] mq_d [$];
        logic [31:0] m_busy;
        int          m_blocked;
        bit          m_hold;
        m_busy = 32'd0; m_blocked = 0; m_hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            bit had, hs, ps, e_we, e_stall, relv, pushed;
            logic [4:0]  e_a, rel;
            logic [31:0] e_d;
            idle();
            bus.pipe_we    = ($urandom_range(0, 3) != 0) && !m_hold;
            bus.pipe_waddr = 5'($urandom_range(0, 31));
            bus.pipe_wdata = $urandom;
            bus.mc_valid   = ($urandom_range(0, 2) == 0);
            bus.mc_waddr   = 5'($urandom_range(0, 7));
            bus.mc_wdata   = $urandom;
            bus.re1 = $urandom_range(0, 1); bus.raddr1 = 5'($urandom_range(0, 7));
            bus.re2 = $urandom_range(0, 1); bus.raddr2 = 5'($urandom_range(0, 7));
            bus.id_we = $urandom_range(0, 1); bus.id_waddr = 5'($urandom_range(0, 7));
            had = (mq_a.size() > 0);
            hs  = had && (m_hold || !bus.pipe_we);
            ps  = bus.pipe_we && !hs;
            e_we = 1'b0; e_a = 5'd0; e_d = 32'd0;
            if (hs && mq_a[0] != 5'd0) begin
                e_we = 1'b1; e_a = mq_a[0]; e_d = mq_d[0];
            end else if (ps && bus.pipe_waddr != 5'd0) begin
                e_we = 1'b1; e_a = bus.pipe_waddr; e_d = bus.pipe_wdata;
            end
            relv = hs && (mq_a[0] != 5'd0);
            rel  = relv ? mq_a[0] : 5'd0;
            e_stall = m_hold
                || (bus.re1 && m_busy[bus.raddr1] && !(relv && rel == bus.raddr1))
                || (bus.re2 && m_busy[bus.raddr2] && !(relv && rel == bus.raddr2))
                || (bus.id_we && m_busy[bus.id_waddr] && !(relv && rel == bus.id_waddr));
            bus.iss_valid = ($urandom_range(0, 3) == 0) && !e_stall;
            bus.iss_waddr = 5'($urandom_range(0, 7));
            sample();
            checks++;
            if ({bus.we, bus.waddr, bus.wdata} !== {e_we, e_a, e_d})
                $display("FAIL rand_write c%0d: got we=%0b waddr=%0d wdata=%h want %0b/%0d/%h",
                         c, bus.we, bus.waddr, bus.wdata, e_we, e_a, e_d);
            else passes++;
            checks++;
            if ({bus.stall, bus.mc_ready, bus.pipe_hold} !== {e_stall, (mq_a.size() < 2), m_hold})
                $display("FAIL rand_ctrl c%0d: got stall=%0b ready=%0b hold=%0b want %0b/%0b/%0b",
                         c, bus.stall, bus.mc_ready, bus.pipe_hold, e_stall, (mq_a.size() < 2), m_hold);
            else passes++;
            pushed = bus.mc_valid && (mq_a.size() < 2);
            if (hs) begin
                void'(mq_a.pop_front());
                void'(mq_d.pop_front());
            end
            if (pushed) begin
                mq_a.push_back(bus.mc_waddr);
                mq_d.push_back(bus.mc_wdata);
            end
            if (relv) m_busy[rel] = 1'b0;
            if (bus.iss_valid && bus.iss_waddr != 5'd0) m_busy[bus.iss_waddr] = 1'b1;
            if (had && !hs) m_blocked++;
            else m_blocked = 0;
            m_hold = had && !hs && (m_blocked == 3);
            step();
        end
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_r0();
        test_scoreboard();
        test_starvation();
        test_full_fifo();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
